// File: rtl/can_defs_pkg.sv
// Shared CAN receive definitions: FSM states, error codes, FIFO entry, CRC helper.
package can_defs;

  localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;

  typedef enum logic [4:0] {
    STATE_IDLE,
    STATE_ID_STD,
    STATE_BIT_RTR_1,
    STATE_BIT_IDE,
    STATE_ID_EXT,
    STATE_BIT_RTR_2,
    STATE_BIT_R_1,
    STATE_BIT_R_0,
    STATE_DLC,
    STATE_DATA,
    STATE_CRC,
    STATE_CRC_DELIMIT,
    STATE_ACK,
    STATE_ACK_DELIMIT,
    STATE_EOF,
    STATE_IFS,
    STATE_ERROR
  } type_can_frame_states_e;

  typedef enum logic [1:0] {
    ERR_STUFF = 2'd0,
    ERR_FORM  = 2'd1,
    ERR_CRC   = 2'd2
  } type_can_rx_err_e;

  // Data is always 8 bytes wide here; the top exposes only the configured bytes.
  typedef struct packed {
    logic [10:0] id_std;
    logic [17:0] id_ext;
    logic        ide;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
  } can_rx_entry_t;

  // One serial step of the CAN CRC-15 register.
  function automatic logic [14:0] can_crc15_step(input logic [14:0] crc, input logic b);
    return {crc[13:0], 1'b0} ^ ((b ^ crc[14]) ? CAN_CRC15_POLY : 15'h0);
  endfunction

  // Number of data bytes carried on the wire for a given RTR/DLC.
  function automatic logic [3:0] can_byte_count(input logic rtr, input logic [3:0] dlc);
    return rtr ? 4'd0 : ((dlc > 4'd8) ? 4'd8 : dlc);
  endfunction

endpackage

// File: rtl/can_rx_frame_fifo.sv
// Frame FIFO of can_rx_entry_t; a pop in the same cycle frees room for a push when full.
module can_rx_frame_fifo
  import can_defs::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  can_rx_entry_t                  push_entry,
  input  logic                           pop,
  output can_rx_entry_t                  head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  can_rx_entry_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             rd_c;
  logic             wr_c;
  logic [CNT_W-1:0] count_nxt_c;

  // Accept a write when space exists now or is freed by this cycle's read.
  always_comb begin
    rd_c        = pop && !empty;
    wr_c        = push && (!full || rd_c);
    count_nxt_c = count + CNT_W'(wr_c) - CNT_W'(rd_c);
  end

  // Storage, pointers and registered occupancy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_c) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (rd_c) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      count <= count_nxt_c;
      full  <= (count_nxt_c == CNT_W'(DEPTH));
      empty <= (count_nxt_c == '0);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/can_rx_frame_engine.sv
// CAN bit-level frame receiver with destuffing, CRC-15, form/stuff checks and a frame FIFO.
// Optional acceptance filter: define CAN_RX_ACCEPT_FILTER_EN.
module can_rx_frame_engine
  import can_defs::*;
#(
  parameter int unsigned RX_FIFO_DEPTH       = 2,
  parameter int unsigned MAX_DATA_BYTES      = 8,
  parameter int unsigned IDLE_RECESSIVE_BITS = 11
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 rx_bit,
  input  logic                                 sample_point,
`ifdef CAN_RX_ACCEPT_FILTER_EN
  input  logic [28:0]                          acc_code,
  input  logic [28:0]                          acc_mask,
`endif
  output logic                                 frame_valid,
  input  logic                                 frame_ready,
  output logic [10:0]                          frame_id_std,
  output logic [17:0]                          frame_id_ext,
  output logic                                 frame_ide,
  output logic                                 frame_rtr,
  output logic [3:0]                           frame_dlc,
  output logic [8*MAX_DATA_BYTES-1:0]          frame_data,
  output logic                                 rx_busy,
  output logic                                 ack_slot,
  output logic                                 rx_error,
  output logic [1:0]                           rx_error_code,
  output logic                                 rx_overflow,
  output logic [$clog2(RX_FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned IDLE_W = $clog2(IDLE_RECESSIVE_BITS + 1);

  type_can_frame_states_e state;
  logic [5:0]        bit_cnt;
  logic [2:0]        run_cnt;
  logic              last_bit;
  logic [14:0]       crc;
  logic [13:0]       crc_rx;
  logic [10:0]       id_std_q;
  logic [17:0]       id_ext_q;
  logic              ide_q;
  logic              rtr_q;
  logic [3:0]        dlc_q;
  logic [3:0]        byte_cnt;
  logic [63:0]       data_q;
  logic [IDLE_W-1:0] idle_cnt;

  logic              in_stuff_c;
  logic              stuff_bit_c;
  logic              crc_en_c;
  logic              err_c;
  type_can_rx_err_e  err_code_c;
  logic              accept_c;
  logic              push_c;
  logic              pop_c;
  can_rx_entry_t     push_entry_c;
  can_rx_entry_t     head;
  logic              fifo_full;
  logic              fifo_empty;

  // Destuff window, CRC window and error detection for the current sample.
  always_comb begin
    in_stuff_c = 1'b0;
    crc_en_c   = 1'b0;
    err_c      = 1'b0;
    err_code_c = ERR_STUFF;
    case (state)
      STATE_ID_STD, STATE_BIT_RTR_1, STATE_BIT_IDE, STATE_ID_EXT, STATE_BIT_RTR_2,
      STATE_BIT_R_1, STATE_BIT_R_0, STATE_DLC, STATE_DATA: begin
        in_stuff_c = 1'b1;
        crc_en_c   = 1'b1;
      end
      STATE_CRC:         in_stuff_c = 1'b1;
      // A stuff bit may still follow the last CRC bit.
      STATE_CRC_DELIMIT: in_stuff_c = (run_cnt == 3'd5);
      default: ;
    endcase
    stuff_bit_c = in_stuff_c && (run_cnt == 3'd5);
    if (stuff_bit_c) crc_en_c = 1'b0;
    if (sample_point) begin
      if (stuff_bit_c) begin
        if (rx_bit == last_bit) begin
          err_c      = 1'b1;
          err_code_c = ERR_STUFF;
        end
      end else begin
        case (state)
          STATE_CRC: begin
            if (bit_cnt == 6'd14 && {crc_rx, rx_bit} != crc) begin
              err_c      = 1'b1;
              err_code_c = ERR_CRC;
            end
          end
          STATE_CRC_DELIMIT, STATE_ACK_DELIMIT, STATE_EOF: begin
            if (!rx_bit) begin
              err_c      = 1'b1;
              err_code_c = ERR_FORM;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CAN_RX_ACCEPT_FILTER_EN
  logic [28:0] filt_key_c;
  assign filt_key_c = {id_std_q, ide_q ? id_ext_q : 18'h0};
  assign accept_c   = (((filt_key_c ^ acc_code) & acc_mask) == 29'h0);
`else
  assign accept_c = 1'b1;
`endif

  // Frame is committed on the last EOF bit when it is recessive.
  always_comb begin
    push_c              = sample_point && (state == STATE_EOF) && (bit_cnt == 6'd6)
                          && rx_bit && accept_c;
    pop_c               = frame_valid && frame_ready;
    push_entry_c        = '0;
    push_entry_c.id_std = id_std_q;
    push_entry_c.id_ext = ide_q ? id_ext_q : 18'h0;
    push_entry_c.ide    = ide_q;
    push_entry_c.rtr    = rtr_q;
    push_entry_c.dlc    = dlc_q;
    push_entry_c.data   = data_q;
  end

  // Frame FSM, destuffer, CRC and status outputs; advances only on sample_point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= STATE_IDLE;
      bit_cnt       <= '0;
      run_cnt       <= '0;
      last_bit      <= 1'b0;
      crc           <= '0;
      crc_rx        <= '0;
      id_std_q      <= '0;
      id_ext_q      <= '0;
      ide_q         <= 1'b0;
      rtr_q         <= 1'b0;
      dlc_q         <= '0;
      byte_cnt      <= '0;
      data_q        <= '0;
      idle_cnt      <= '0;
      rx_busy       <= 1'b0;
      ack_slot      <= 1'b0;
      rx_error      <= 1'b0;
      rx_error_code <= '0;
      rx_overflow   <= 1'b0;
    end else begin
      rx_error    <= 1'b0;
      rx_overflow <= push_c && fifo_full && !pop_c;
      if (sample_point) begin
        if (stuff_bit_c) begin
          run_cnt  <= 3'd1;
          last_bit <= rx_bit;
        end else begin
          if (in_stuff_c) begin
            run_cnt  <= (rx_bit == last_bit) ? run_cnt + 3'd1 : 3'd1;
            last_bit <= rx_bit;
          end
          if (crc_en_c) crc <= can_crc15_step(crc, rx_bit);
          bit_cnt <= bit_cnt + 6'd1;
          case (state)
            STATE_IDLE, STATE_IFS: begin
              if (!rx_bit) begin
                // SOF: the bit is dominant so the CRC stays at zero after it.
                state    <= STATE_ID_STD;
                bit_cnt  <= '0;
                run_cnt  <= 3'd1;
                last_bit <= 1'b0;
                crc      <= '0;
                id_std_q <= '0;
                id_ext_q <= '0;
                ide_q    <= 1'b0;
                rtr_q    <= 1'b0;
                dlc_q    <= '0;
                data_q   <= '0;
                rx_busy  <= 1'b1;
              end else if (state == STATE_IFS && bit_cnt == 6'd2) begin
                state   <= STATE_IDLE;
                rx_busy <= 1'b0;
              end
            end
            STATE_ID_STD: begin
              id_std_q <= {id_std_q[9:0], rx_bit};
              if (bit_cnt == 6'd10) begin
                state   <= STATE_BIT_RTR_1;
                bit_cnt <= '0;
              end
            end
            STATE_BIT_RTR_1: begin
              rtr_q <= rx_bit;
              state <= STATE_BIT_IDE;
            end
            STATE_BIT_IDE: begin
              ide_q   <= rx_bit;
              state   <= rx_bit ? STATE_ID_EXT : STATE_BIT_R_0;
              bit_cnt <= '0;
            end
            STATE_ID_EXT: begin
              id_ext_q <= {id_ext_q[16:0], rx_bit};
              if (bit_cnt == 6'd17) begin
                state   <= STATE_BIT_RTR_2;
                bit_cnt <= '0;
              end
            end
            STATE_BIT_RTR_2: begin
              rtr_q <= rx_bit;
              state <= STATE_BIT_R_1;
            end
            STATE_BIT_R_1: state <= STATE_BIT_R_0;
            STATE_BIT_R_0: begin
              state   <= STATE_DLC;
              bit_cnt <= '0;
            end
            STATE_DLC: begin
              dlc_q <= {dlc_q[2:0], rx_bit};
              if (bit_cnt == 6'd3) begin
                byte_cnt <= can_byte_count(rtr_q, {dlc_q[2:0], rx_bit});
                state    <= (can_byte_count(rtr_q, {dlc_q[2:0], rx_bit}) == 4'd0)
                            ? STATE_CRC : STATE_DATA;
                bit_cnt  <= '0;
              end
            end
            STATE_DATA: begin
              // MSB first within each byte; bytes past the storage limit are dropped.
              if ({1'b0, bit_cnt[5:3]} < 4'(MAX_DATA_BYTES))
                data_q[{bit_cnt[5:3], ~bit_cnt[2:0]}] <= rx_bit;
              if ({1'b0, bit_cnt} == {byte_cnt, 3'b000} - 7'd1) begin
                state   <= STATE_CRC;
                bit_cnt <= '0;
              end
            end
            STATE_CRC: begin
              crc_rx <= {crc_rx[12:0], rx_bit};
              if (bit_cnt == 6'd14) state <= STATE_CRC_DELIMIT;
            end
            STATE_CRC_DELIMIT: begin
              state    <= STATE_ACK;
              ack_slot <= 1'b1;
            end
            STATE_ACK: begin
              state    <= STATE_ACK_DELIMIT;
              ack_slot <= 1'b0;
            end
            STATE_ACK_DELIMIT: begin
              state   <= STATE_EOF;
              bit_cnt <= '0;
            end
            STATE_EOF: begin
              if (bit_cnt == 6'd6) begin
                state   <= STATE_IFS;
                bit_cnt <= '0;
              end
            end
            STATE_ERROR: begin
              if (!rx_bit) begin
                idle_cnt <= '0;
              end else if (idle_cnt == IDLE_W'(IDLE_RECESSIVE_BITS - 1)) begin
                state   <= STATE_IDLE;
                rx_busy <= 1'b0;
              end else begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
              end
            end
            default: state <= STATE_IDLE;
          endcase
        end
        if (err_c) begin
          state         <= STATE_ERROR;
          rx_error      <= 1'b1;
          rx_error_code <= err_code_c;
          idle_cnt      <= '0;
          ack_slot      <= 1'b0;
        end
      end
    end
  end

  can_rx_frame_fifo #(
    .DEPTH (RX_FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_c),
    .push_entry (push_entry_c),
    .pop        (pop_c),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign frame_valid  = !fifo_empty;
  assign frame_id_std = head.id_std;
  assign frame_id_ext = head.id_ext;
  assign frame_ide    = head.ide;
  assign frame_rtr    = head.rtr;
  assign frame_dlc    = head.dlc;
  assign frame_data   = head.data[8*MAX_DATA_BYTES-1:0];

endmodule
